// File: rtl/face_point_gen_if.sv
// face_point_gen_if: read port toward the mesh RAM plus the face-point
// output stream. The face-point stage drives the master side.
interface face_point_gen_if;
   logic        mem_en;
   logic        mem_wr;
   logic [3:0]  mem_we;
   logic [31:0] mem_din;
   logic [10:0] mem_addr;
   logic [31:0] mem_dout;
   logic        fp_valid;
   logic        fp_ready;
   logic [31:0] fp_x;
   logic [31:0] fp_y;
   logic [31:0] fp_z;
   logic [8:0]  fp_face;

   modport master (
      output mem_en, mem_wr, mem_we, mem_din, mem_addr,
      input  mem_dout,
      output fp_valid, fp_x, fp_y, fp_z, fp_face,
      input  fp_ready
   );

   modport slave (
      input  mem_en, mem_wr, mem_we, mem_din, mem_addr,
      output mem_dout,
      input  fp_valid, fp_x, fp_y, fp_z, fp_face,
      output fp_ready
   );
endinterface

// File: rtl/face_point_gen.sv
// face_point_gen: walks the quad face table in the mesh RAM, fetches the four
// vertices of each face and emits the centroid (sum of 4 signed Q16.16
// coordinates, shifted right by 2) on a valid/ready stream.
// Optional macro FACE_POINT_ROUND_EN: round to nearest (ties toward +inf)
// instead of flooring. Latency and interface are the same in both builds.
module face_point_gen #(
   parameter logic [10:0] FACE_BASE = 11'h000,
   parameter logic [10:0] VERT_BASE = 11'h200
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [8:0]       num_faces,
   output logic             busy,
   output logic             done,
   face_point_gen_if.master bus
);

   typedef enum logic [2:0] {
      IDLE, RD_IDX, WAIT_IDX, RD_VTX, WAIT_VTX, OUT, DONE
   } state_t;

   // Describes what the read issued last cycle returns this cycle.
   typedef enum logic [1:0] {CAP_NONE, CAP_IDX, CAP_VTX} cap_t;

   state_t             state, state_nxt;
   cap_t               cap_kind;
   logic [1:0]         cap_sel;
   logic [8:0]         face_cnt;
   logic [8:0]         face_total;
   logic [1:0]         idx_k;
   logic [1:0]         vtx_v;
   logic [1:0]         vtx_c;
   logic [8:0]         idx [4];
   logic signed [33:0] sum_x, sum_y, sum_z;
   logic signed [33:0] sum_x_nxt, sum_y_nxt, sum_z_nxt;
   logic signed [33:0] word_ext;
   logic [10:0]        vtx_off;
   logic               last_face;

   // Sum of four vertices divided by four, floored or rounded.
   function automatic logic [31:0] scale(input logic signed [33:0] s);
      logic signed [33:0] t;
`ifdef FACE_POINT_ROUND_EN
      t = s + 34'sd2;
`else
      t = s;
`endif
      t = t >>> 2;
      return t[31:0];
   endfunction

   assign word_ext  = {{2{bus.mem_dout[31]}}, bus.mem_dout};
   assign vtx_off   = {2'b00, idx[vtx_v]} * 11'd3;
   assign last_face = ({1'b0, face_cnt} + 10'd1) >= {1'b0, face_total};

   // The RAM port is read-only from this stage.
   assign bus.mem_wr  = 1'b0;
   assign bus.mem_we  = 4'h0;
   assign bus.mem_din = 32'h0;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode and the combinational outputs of each state.
   always_comb begin
      // NOTE: every output gets a default up front so no path leaves a
      // variable unassigned, which would otherwise infer a latch.
      state_nxt    = state;
      busy         = 1'b0;
      done         = 1'b0;
      bus.mem_en   = 1'b0;
      bus.mem_addr = 11'h000;
      bus.fp_valid = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = (num_faces == 9'd0) ? DONE : RD_IDX;
         end
         RD_IDX: begin
            busy         = 1'b1;
            bus.mem_en   = 1'b1;
            bus.mem_addr = FACE_BASE + {face_cnt, 2'b00} + {9'd0, idx_k};
            if (idx_k == 2'd3) state_nxt = WAIT_IDX;
         end
         WAIT_IDX: begin
            busy      = 1'b1;
            state_nxt = RD_VTX;
         end
         RD_VTX: begin
            busy         = 1'b1;
            bus.mem_en   = 1'b1;
            bus.mem_addr = VERT_BASE + vtx_off + {9'd0, vtx_c};
            if (vtx_v == 2'd3 && vtx_c == 2'd2) state_nxt = WAIT_VTX;
         end
         WAIT_VTX: begin
            busy      = 1'b1;
            state_nxt = OUT;
         end
         OUT: begin
            busy         = 1'b1;
            bus.fp_valid = 1'b1;
            if (bus.fp_ready) state_nxt = last_face ? DONE : RD_IDX;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Accumulators: cleared on entry to RD_IDX, otherwise fold in the
   // returned vertex word for the component read in the previous cycle.
   always_comb begin
      sum_x_nxt = sum_x;
      sum_y_nxt = sum_y;
      sum_z_nxt = sum_z;
      if (state_nxt == RD_IDX && state != RD_IDX) begin
         sum_x_nxt = '0;
         sum_y_nxt = '0;
         sum_z_nxt = '0;
      end else if (cap_kind == CAP_VTX) begin
         case (cap_sel)
            2'd0:    sum_x_nxt = sum_x + word_ext;
            2'd1:    sum_y_nxt = sum_y + word_ext;
            default: sum_z_nxt = sum_z + word_ext;
         endcase
      end
   end

   // Datapath: read counters, capture tags, index/sum registers, outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_kind    <= CAP_NONE;
         cap_sel     <= 2'd0;
         face_cnt    <= 9'd0;
         face_total  <= 9'd0;
         idx_k       <= 2'd0;
         vtx_v       <= 2'd0;
         vtx_c       <= 2'd0;
         sum_x       <= '0;
         sum_y       <= '0;
         sum_z       <= '0;
         bus.fp_x    <= 32'h0;
         bus.fp_y    <= 32'h0;
         bus.fp_z    <= 32'h0;
         bus.fp_face <= 9'd0;
         // NOTE: idx is only four registers, not a RAM macro, so it is
         // reset like any other flop to give a defined post-reset state.
         for (int i = 0; i < 4; i++) idx[i] <= 9'd0;
      end else begin
         sum_x <= sum_x_nxt;
         sum_y <= sum_y_nxt;
         sum_z <= sum_z_nxt;

         case (state)
            RD_IDX: begin
               cap_kind <= CAP_IDX;
               cap_sel  <= idx_k;
            end
            RD_VTX: begin
               cap_kind <= CAP_VTX;
               cap_sel  <= vtx_c;
            end
            default: begin
               cap_kind <= CAP_NONE;
               cap_sel  <= 2'd0;
            end
         endcase

         if (cap_kind == CAP_IDX) idx[cap_sel] <= bus.mem_dout[8:0];

         if (state == RD_IDX) idx_k <= idx_k + 2'd1;
         else                 idx_k <= 2'd0;

         if (state == RD_VTX) begin
            if (vtx_c == 2'd2) begin
               vtx_c <= 2'd0;
               vtx_v <= vtx_v + 2'd1;
            end else begin
               vtx_c <= vtx_c + 2'd1;
            end
         end else begin
            vtx_c <= 2'd0;
            vtx_v <= 2'd0;
         end

         if (state == IDLE && start) begin
            face_cnt   <= 9'd0;
            face_total <= num_faces;
         end else if (state == OUT && bus.fp_ready && !last_face) begin
            face_cnt <= face_cnt + 9'd1;
         end

         if (state == WAIT_VTX) begin
            bus.fp_x    <= scale(sum_x_nxt);
            bus.fp_y    <= scale(sum_y_nxt);
            bus.fp_z    <= scale(sum_z_nxt);
            bus.fp_face <= face_cnt;
         end
      end
   end

endmodule

// File: doc/face_point_gen.md
# face_point_gen

Face-point generation stage that sits directly downstream of the 2048x32 quad-bank mesh RAM: it walks a quad face table stored in that RAM, fetches the four referenced vertices, and emits each face's centroid (component-wise average of 4 signed Q16.16 coordinates) on a valid/ready stream. It is the RAM's only reader during the face-point pass, and the edge-point stage consumes its output.

## Interface
- FACE_BASE, default 11'h000: word address of face 0; face f occupies words FACE_BASE+4f .. +4f+3, one vertex index per word.
- VERT_BASE, default 11'h200: word address of vertex 0; vertex i occupies words VERT_BASE+3i (x), +1 (y), +2 (z).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a pass; sampled only in IDLE.
- num_faces  in  9  faces to process; sampled with start.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse at the end of a pass.
- mem_en  out  1  RAM enable; high only in cycles that issue a read.
- mem_wr  out  1  tied 0.
- mem_we  out  4  tied 4'h0.
- mem_din  out  32  tied 0.
- mem_addr  out  11  RAM word address.
- mem_dout  in  32  RAM read data, valid the cycle after mem_en.
- fp_valid  out  1  face point available.
- fp_ready  in  1  downstream accept.
- fp_x, fp_y, fp_z  out  32 each  signed Q16.16 face point.
- fp_face  out  9  face number of the current output.

## Operation
- States: IDLE, RD_IDX, WAIT_IDX, RD_VTX, WAIT_VTX, OUT, DONE.
- IDLE: start=1 with num_faces=0 -> DONE (no RAM access); start=1 otherwise -> RD_IDX with face counter f=0.
- RD_IDX, 4 cycles: mem_addr = FACE_BASE+4f+k, k=0..3. The low 9 bits of each returned word are captured as idx[k]; bits [31:9] are ignored.
- WAIT_IDX, 1 cycle: captures idx[3].
- RD_VTX, 12 cycles: reads in the order v0.x, v0.y, v0.z, v1.x … v3.z. mem_addr = VERT_BASE + 3*idx[v] + c.
- Returned words are sign-extended to 34 bits and added to sum_x, sum_y or sum_z. The sums are cleared on entry to RD_IDX.
- WAIT_VTX, 1 cycle: captures the last word, then -> OUT.
- OUT: fp_valid=1 and fp_* = sum>>>2 (arithmetic shift, truncated to 32 bits, floor).
  - If fp_valid && fp_ready and f+1 < num_faces: f++ and -> RD_IDX.
  - Otherwise on handshake -> DONE.
- DONE: done=1 for one cycle, then -> IDLE.
- All address arithmetic is modulo 2048; wrap past 11'h7FF is legal and silent.
- start while busy is ignored, and num_faces is not re-sampled.
- Addresses that duplicate vertex indices are read again; there is no caching.

## Timing
- Reset values: state IDLE; busy, done, mem_en, fp_valid = 0; mem_addr = 0; fp_x/y/z, fp_face, sums and idx = 0.
- Reset is asynchronous mid-pass: the machine returns to IDLE immediately, any pending fp_valid drops, and no done pulse is issued.
- Count the start-sampling edge as cycle 0:
  - cycles 1–4 RD_IDX
  - cycle 5 WAIT_IDX
  - cycles 6–17 RD_VTX
  - cycle 18 WAIT_VTX
  - fp_valid first high in cycle 19.
- With fp_ready held high, each face occupies 19 cycles (18 fetch cycles + 1 OUT cycle).
- After the last face's handshake, done pulses in the next cycle.
- fp_x/y/z and fp_face are registered and stay stable while fp_valid && !fp_ready. fp_valid never drops without a handshake, except on reset.
- mem_en is 0 in every state except RD_IDX and RD_VTX.

## Configuration
- FACE_POINT_ROUND_EN defined: fp = (sum + 2)>>>2, which rounds to nearest with ties toward +inf.
- FACE_POINT_ROUND_EN undefined: fp = sum>>>2 (floor).
- Latency and interface are identical in both builds.

## Test plan
- Single face, num_faces=1, indices 0,1,2,3, vertices x = 0x00010000, 0x00020000, 0x00030000, 0x00040000 (y=z=x) -> fp_x = 0x00028000 in cycle 19, then done one cycle after the handshake.
- Three faces with fp_ready low for 5 cycles at each OUT -> outputs held stable, fp_face 0,1,2 in order, exactly 3 handshakes, one done pulse.
- num_faces=0 -> done in cycle 1, mem_en never asserted, busy stays 0.
- VERT_BASE=11'h7FE, index 1 -> vertex reads at addresses 0x001, 0x002, 0x003 (wrap), with correct sums.
- x values −1, 0, 0, 0 (0xFFFFFFFF, 0, 0, 0) -> 0xFFFFFFFF without FACE_POINT_ROUND_EN, 0x00000000 with it.
- rst_n asserted in cycle 10 of a pass -> all outputs 0 immediately, no done; a new start afterwards completes normally, and start pulses during busy are ignored.
